// File: rtl/pc_gen_if.sv
// Fetch-stage PC generator bus: decoder-side controls in, fetch address and status out.
interface pc_gen_if #(
    parameter int ADDR_W = 32
);
    logic              pcg_stall;
    logic              pcg_branch;
    logic              pcg_jmp;
    logic              pcg_jr;
    logic              pcg_exc;
    logic              pcg_eret;
    logic              pcg_halt;
    logic [ADDR_W-1:0] pcg_offset_addr;
    logic [ADDR_W-1:0] pcg_jr_addr;
    logic [ADDR_W-1:0] pcg_pc_out;
    logic              pcg_valid;
    logic [ADDR_W-1:0] pcg_epc;
    logic [1:0]        pcg_state;

    // Decoder / control side
    modport master (
        output pcg_stall, pcg_branch, pcg_jmp, pcg_jr, pcg_exc, pcg_eret, pcg_halt,
        output pcg_offset_addr, pcg_jr_addr,
        input  pcg_pc_out, pcg_valid, pcg_epc, pcg_state
    );

    // PC generator side
    modport slave (
        input  pcg_stall, pcg_branch, pcg_jmp, pcg_jr, pcg_exc, pcg_eret, pcg_halt,
        input  pcg_offset_addr, pcg_jr_addr,
        output pcg_pc_out, pcg_valid, pcg_epc, pcg_state
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: startup wait, prioritised
// next-PC selection, stall/halt, and EPC capture on exceptions.
module pc_gen #(
    parameter int              ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int              WAIT_CYCLES  = 4
) (
    input logic     pcg_clk,
    input logic     pcg_rst,
    pc_gen_if.slave pcg_bus
);
    typedef enum logic [1:0] {
        ST_WAIT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    // Last counter value before leaving WAIT; WAIT_CYCLES=0 is special-cased below.
    localparam logic [7:0] WAIT_LAST = 8'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [7:0]        cnt_q, cnt_d;

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] jmp_tgt;

    assign pc4     = pc_q + ADDR_W'(4);
    assign br_tgt  = pc4 + {pcg_bus.pcg_offset_addr[ADDR_W-3:0], 2'b00};
    assign jmp_tgt = {pc4[ADDR_W-1:28], pcg_bus.pcg_offset_addr[25:0], 2'b00};

    // State, PC, EPC and wait-counter registers with synchronous reset.
    always_ff @(posedge pcg_clk) begin
        if (pcg_rst) begin
            state_q <= ST_WAIT;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-PC selection; lower-priority requests are simply dropped.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                // Counter only paces the startup wait; it saturates and is unused afterwards.
                if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                if (WAIT_CYCLES == 0 || cnt_q == WAIT_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (pcg_bus.pcg_exc) begin
                    epc_d = pc_q;
                    pc_d  = EXC_VECTOR;
                end else if (pcg_bus.pcg_halt) begin
                    state_d = ST_HALT;
                end else if (pcg_bus.pcg_eret) begin
                    pc_d = epc_q;
                end else if (pcg_bus.pcg_stall) begin
                    pc_d = pc_q;
                end else if (pcg_bus.pcg_branch) begin
                    pc_d = br_tgt;
                end else if (pcg_bus.pcg_jmp) begin
                    pc_d = jmp_tgt;
                end else if (pcg_bus.pcg_jr) begin
                    // A misaligned jr target raises an exception instead of jumping.
                    if (pcg_bus.pcg_jr_addr[1:0] == 2'b00) begin
                        pc_d = pcg_bus.pcg_jr_addr;
                    end else begin
                        epc_d = pc_q;
                        pc_d  = EXC_VECTOR;
                    end
                end else begin
                    pc_d = pc4;
                end
            end
            ST_HALT: begin
                // Frozen until reset.
            end
            default: state_d = ST_WAIT;
        endcase
    end

    assign pcg_bus.pcg_pc_out = pc_q;
    assign pcg_bus.pcg_valid  = (state_q == ST_RUN);
    assign pcg_bus.pcg_epc    = epc_q;
    assign pcg_bus.pcg_state  = state_q;
endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus pushes expected post-edge values,
// a monitor pops and compares one entry per clock.
module tb_pc_gen;
    localparam logic [1:0] WT = 2'b00;
    localparam logic [1:0] RN = 2'b01;
    localparam logic [1:0] HL = 2'b10;

    // control bit order: stall, branch, jmp, jr, exc, eret, halt
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_STALL  = 7'b1000000;
    localparam logic [6:0] C_BRANCH = 7'b0100000;
    localparam logic [6:0] C_JMP    = 7'b0010000;
    localparam logic [6:0] C_JR     = 7'b0001000;
    localparam logic [6:0] C_EXC    = 7'b0000100;
    localparam logic [6:0] C_ERET   = 7'b0000010;
    localparam logic [6:0] C_HALT   = 7'b0000001;

    typedef struct {
        logic [31:0] pc;
        logic        v;
        logic [1:0]  st;
        logic [31:0] epc;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_gen_if #(.ADDR_W(32)) bus ();
    pc_gen_if #(.ADDR_W(32)) bus2 ();

    pc_gen #(
        .ADDR_W(32), .RESET_VECTOR(32'h0000_0000),
        .EXC_VECTOR(32'h8000_0180), .WAIT_CYCLES(4)
    ) dut (
        .pcg_clk(clk), .pcg_rst(rst), .pcg_bus(bus)
    );

    pc_gen #(
        .ADDR_W(32), .RESET_VECTOR(32'hFFFF_FFF8),
        .EXC_VECTOR(32'h8000_0180), .WAIT_CYCLES(0)
    ) dut2 (
        .pcg_clk(clk), .pcg_rst(rst), .pcg_bus(bus2)
    );

    exp_t q1[$];
    exp_t q2[$];
    int checks = 0;
    int errors = 0;

    task automatic compare(input exp_t e, input logic [31:0] pc, input logic v,
                           input logic [1:0] st, input logic [31:0] epc);
        checks++;
        if (pc !== e.pc || v !== e.v || st !== e.st || epc !== e.epc) begin
            errors++;
            $display("FAIL %s: got pc=%h v=%b st=%b epc=%h, want pc=%h v=%b st=%b epc=%h",
                     e.nm, pc, v, st, epc, e.pc, e.v, e.st, e.epc);
        end
    endtask

    // Monitor: outputs are presented every cycle; check just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                compare(e, bus.pcg_pc_out, bus.pcg_valid, bus.pcg_state, bus.pcg_epc);
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                compare(e, bus2.pcg_pc_out, bus2.pcg_valid, bus2.pcg_state, bus2.pcg_epc);
            end
        end
    end

    task automatic step(input logic r, input logic [6:0] c, input logic [31:0] off,
                        input logic [31:0] jra, input logic [31:0] pc, input logic v,
                        input logic [1:0] st, input logic [31:0] epc, input string nm);
        exp_t e;
        rst = r;
        {bus.pcg_stall, bus.pcg_branch, bus.pcg_jmp, bus.pcg_jr,
         bus.pcg_exc, bus.pcg_eret, bus.pcg_halt} = c;
        bus.pcg_offset_addr = off;
        bus.pcg_jr_addr     = jra;
        e = '{pc, v, st, epc, nm};
        q1.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic push2(input logic [31:0] pc, input logic v, input logic [1:0] st,
                         input string nm);
        exp_t e;
        e = '{pc, v, st, 32'h0, nm};
        q2.push_back(e);
    endtask

    initial begin
        {bus2.pcg_stall, bus2.pcg_branch, bus2.pcg_jmp, bus2.pcg_jr,
         bus2.pcg_exc, bus2.pcg_eret, bus2.pcg_halt} = 7'b0;
        bus2.pcg_offset_addr = '0;
        bus2.pcg_jr_addr     = '0;

        // Startup: 2 reset cycles, 4 WAIT cycles, then sequential fetch.
        // dut2 (WAIT_CYCLES=0, near-top reset vector) wraps through zero meanwhile.
        push2(32'hFFFF_FFF8, 1'b0, WT, "w_rst0");
        step(1, C_NONE, 0, 0, 32'h0, 0, WT, 0, "rst0");
        push2(32'hFFFF_FFF8, 1'b0, WT, "w_rst1");
        step(1, C_NONE, 0, 0, 32'h0, 0, WT, 0, "rst1");
        push2(32'hFFFF_FFF8, 1'b1, RN, "w_run_f8");
        step(0, C_EXC, 0, 0, 32'h0, 0, WT, 0, "wait_a");
        push2(32'hFFFF_FFFC, 1'b1, RN, "w_run_fc");
        step(0, C_BRANCH, 5, 0, 32'h0, 0, WT, 0, "wait_b");
        push2(32'h0000_0000, 1'b1, RN, "w_wrap0");
        step(0, C_HALT, 0, 0, 32'h0, 0, WT, 0, "wait_c");
        push2(32'h0000_0004, 1'b1, RN, "w_wrap4");
        step(0, C_NONE, 0, 0, 32'h0, 1, RN, 0, "run_0");
        step(0, C_NONE, 0, 0, 32'h4, 1, RN, 0, "run_4");
        step(0, C_NONE, 0, 0, 32'h8, 1, RN, 0, "run_8");
        step(0, C_NONE, 0, 0, 32'hC, 1, RN, 0, "run_c");
        step(0, C_NONE, 0, 0, 32'h10, 1, RN, 0, "run_10");

        // Branch / jump from 0x10
        step(0, C_BRANCH, 32'h0000_0111, 0, 32'h458, 1, RN, 0, "br_fwd");
        step(0, C_BRANCH, 32'hFFFF_FFFE, 0, 32'h454, 1, RN, 0, "br_back");
        step(0, C_JMP, 32'h0000_0001, 0, 32'h4, 1, RN, 0, "jmp");
        for (int k = 1; k <= 7; k++)
            step(0, C_NONE, 0, 0, 32'(4 + 4 * k), 1, RN, 0, "seq_to_20");

        // Priority / stall at 0x20
        step(0, C_STALL | C_BRANCH, 32'h1, 0, 32'h20, 1, RN, 0, "stall_br");
        step(0, C_BRANCH | C_JMP | C_JR, 32'h3, 32'h1000, 32'h30, 1, RN, 0, "br_over_jmp_jr");
        step(0, C_EXC | C_HALT, 0, 0, 32'h8000_0180, 1, RN, 32'h30, "exc_over_halt");
        step(0, C_ERET, 0, 0, 32'h30, 1, RN, 32'h30, "eret_30");
        for (int k = 1; k <= 52; k++)
            step(0, C_NONE, 0, 0, 32'(32'h30 + 4 * k), 1, RN, 32'h30, "seq_to_100");

        // Exception / eret / misaligned jr
        step(0, C_EXC, 0, 0, 32'h8000_0180, 1, RN, 32'h100, "exc_100");
        step(0, C_NONE, 0, 0, 32'h8000_0184, 1, RN, 32'h100, "handler");
        step(0, C_ERET, 0, 0, 32'h100, 1, RN, 32'h100, "eret_100");
        step(0, C_NONE, 0, 0, 32'h104, 1, RN, 32'h100, "seq_104");
        step(0, C_JR, 0, 32'h0000_2002, 32'h8000_0180, 1, RN, 32'h104, "jr_misaligned");
        step(0, C_JR, 0, 32'h0000_0040, 32'h40, 1, RN, 32'h104, "jr_aligned");

        // Halt: frozen despite inputs
        step(0, C_HALT, 0, 0, 32'h40, 0, HL, 32'h104, "halt");
        for (int k = 0; k < 10; k++)
            step(0, C_BRANCH | C_EXC | C_JR | C_ERET, 32'h7, 32'h80, 32'h40, 0, HL, 32'h104,
                 "halt_frozen");

        // Reset out of HALT, then reset again in WAIT cycle 2
        step(1, C_NONE, 0, 0, 32'h0, 0, WT, 0, "rst_halt");
        step(0, C_EXC, 0, 0, 32'h0, 0, WT, 0, "wait2");
        step(1, C_NONE, 0, 0, 32'h0, 0, WT, 0, "rst_in_wait");
        step(0, C_EXC, 0, 0, 32'h0, 0, WT, 0, "rewait_a");
        step(0, C_BRANCH, 32'h9, 0, 32'h0, 0, WT, 0, "rewait_b");
        step(0, C_NONE, 0, 0, 32'h0, 0, WT, 0, "rewait_c");
        step(0, C_NONE, 0, 0, 32'h0, 1, RN, 0, "rerun_0");
        step(0, C_NONE, 0, 0, 32'h4, 1, RN, 0, "rerun_4");

        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d entries left, want 0/0", q1.size(), q2.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the MIPS core's fetch stage.
- Holds the current fetch address and applies a startup wait.
- Applies next-PC selection: sequential, branch, jump, jump-register, exception, exception return.
- Supports stall and halt, and captures the EPC.
- Successor to the fixed 32-bit PC unit: adds width/vector/wait parameters, sync reset, stall, jr, exception/eret, halt and a state output.

Parameters:
ADDR_W, 32, PC width in bits; legal range 29..64
RESET_VECTOR, 32'h0000_0000, PC value after reset
EXC_VECTOR, 32'h8000_0180, PC loaded on exception
WAIT_CYCLES, 4, cycles held in WAIT after reset before the first PC update; legal range 0..255

Ports:
pcg_clk  in  1  single clock; all state updates on rising edge
pcg_rst  in  1  synchronous, active-high reset
pcg_stall  in  1  hold PC this cycle
pcg_branch  in  1  short branch; pcg_offset_addr is sign-extended word offset
pcg_jmp  in  1  long jump; pcg_offset_addr[25:0] is target word index
pcg_jr  in  1  jump register to pcg_jr_addr
pcg_exc  in  1  take exception
pcg_eret  in  1  return from exception
pcg_halt  in  1  stop fetching
pcg_offset_addr  in  ADDR_W  branch offset / jump index
pcg_jr_addr  in  ADDR_W  jr target byte address
pcg_pc_out  out  ADDR_W  current fetch address (registered)
pcg_valid  out  1  pcg_pc_out is a fetch address this cycle
pcg_epc  out  ADDR_W  captured exception PC
pcg_state  out  2  00 WAIT, 01 RUN, 10 HALT

Behaviour:
- Reset (pcg_rst=1 at an edge, wins over everything, including mid-operation):
  - pc=RESET_VECTOR, epc=0, wait counter=0, state=WAIT, pcg_valid=0.
- Latency and timing:
  - All inputs are sampled at the rising edge; the new PC appears on pcg_pc_out after that edge (1-cycle latency).
  - No modelled delays.
- pc4 = pc+4. All arithmetic is modulo 2^ADDR_W; wrap-around from all-ones is allowed silently.
- WAIT state:
  - pc is held and pcg_valid=0; all control inputs are ignored.
  - The counter increments each cycle. State goes to RUN at the edge where the counter equals WAIT_CYCLES-1, i.e. exactly WAIT_CYCLES WAIT cycles after reset release.
  - If WAIT_CYCLES=0, WAIT lasts one cycle only.
  - The counter saturates and is not used in RUN.
- RUN state: pcg_valid=1. Per-edge priority, highest first:
  1. exc: epc<=pc; pc<=EXC_VECTOR.
  2. halt: state<=HALT; pc held.
  3. eret: pc<=epc.
  4. stall: pc held; branch/jmp/jr this cycle are dropped. The decoder re-presents them.
  5. branch: pc<=pc4+(pcg_offset_addr<<2).
  6. jmp: pc<={pc4[ADDR_W-1:28], pcg_offset_addr[25:0], 2'b00}.
  7. jr:
     - If pcg_jr_addr[1:0]==0: pc<=pcg_jr_addr.
     - Otherwise treated as an exception: epc<=pc, pc<=EXC_VECTOR.
  8. none: pc<=pc4.
- Simultaneous lower-priority requests are ignored, not queued.
- HALT state:
  - pc and epc are frozen, pcg_valid=0, all inputs except reset are ignored.
  - Exit only via reset.
- pcg_epc reflects the epc register directly. It is written only on exception or misaligned jr.

Test Plan:
- Startup (WAIT_CYCLES=4, RESET_VECTOR=0): hold reset 2 cycles, release, no controls.
  -> pcg_pc_out=0 with valid=0 for 4 cycles.
  -> Then state=01, valid=1, and PC sequence 0, 4, 8, 0xC on successive edges.
- Branch/jump from pc=0x10:
  - branch with offset 0x0000_0111 -> next pc=0x458.
  - branch with offset 0xFFFF_FFFE -> next pc=0x458+4-8=0x454.
  - jmp with offset 0x0000_0001 at pc=0x454 -> next pc=0x0000_0004.
- Priority/stall:
  - At pc=0x20: stall+branch together -> pc stays 0x20.
  - Next cycle branch+jmp+jr together (offset 0x3) -> pc=0x30.
  - exc+halt together -> pc=0x8000_0180, state stays RUN.
- Exception/eret:
  - At pc=0x100 assert exc -> pc=0x8000_0180, epc=0x100.
  - 2 cycles later assert eret -> pc=0x100.
  - jr to 0x0000_2002 at pc=0x104 -> pc=0x8000_0180, epc=0x104.
- Halt and mid-operation reset:
  - At pc=0x40 assert halt -> state=10, valid=0, pc frozen at 0x40 for 10 cycles despite branch/exc inputs.
  - Then reset -> pc=0, state=00.
  - Reset asserted during WAIT cycle 2 restarts the full 4-cycle wait.
- Wrap/width (ADDR_W=32): RESET_VECTOR=0xFFFF_FFF8, WAIT_CYCLES=0 -> PC sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
